dead_time_nleg: RTL and testbench

//  Parametrised N-leg dead-time generator and shoot-through interlock for the

---
 rtl/dead_time_nleg_if.sv | 24 ++
 rtl/dead_time_nleg.sv | 134 +++++++++++++
 tb/tb_dead_time_nleg.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dead_time_nleg_if.sv
// Gate-request / gate-drive bundle for the N-leg dead-time generator.
// The master drives requests and configuration; the slave returns the gate drives and status.
interface dead_time_nleg_if #(
  parameter int N_LEG = 2,
  parameter int DT_W  = 8
);
  logic               i_enable;
  logic [2*N_LEG-1:0] i_signal;
  logic [DT_W-1:0]    i_deadtime;
  logic               i_fault_clr;
  logic [2*N_LEG-1:0] o_signal;
  logic [N_LEG-1:0]   o_dead;
  logic [N_LEG-1:0]   o_fault;

  modport master (
    output i_enable, i_signal, i_deadtime, i_fault_clr,
    input  o_signal, o_dead, o_fault
  );

  modport slave (
    input  i_enable, i_signal, i_deadtime, i_fault_clr,
    output o_signal, o_dead, o_fault
  );
endinterface

// File: rtl/dead_time_nleg.sv
// N-leg dead-time generator with shoot-through interlock and sticky fault per leg.
// Optional DT_GLOBAL_TRIP_EN: an illegal request on any leg trips and holds every leg.
module dead_time_nleg #(
  parameter int N_LEG = 2,
  parameter int DT_W  = 8
) (
  input logic             i_clock,
  input logic             reset,
  dead_time_nleg_if.slave bus
);

  typedef enum logic [1:0] {ST_OFF, ST_HI_ON, ST_LO_ON, ST_DEAD} state_t;

  state_t             state_q [N_LEG];
  state_t             state_d [N_LEG];
  logic [DT_W-1:0]    cnt_q   [N_LEG];
  logic [DT_W-1:0]    cnt_d   [N_LEG];
  logic [N_LEG-1:0]   target_q, target_d;
  logic [N_LEG-1:0]   fault_q, fault_d;
  logic [N_LEG-1:0]   req_hi, req_lo, req_ill;
  logic [N_LEG-1:0]   trip, clr_ok;
  logic [2*N_LEG-1:0] gate_q, gate_d;
  logic [N_LEG-1:0]   dead_q, dead_d;
  logic [DT_W-1:0]    dt_load;

  always_comb begin
    req_hi  = '0;
    req_lo  = '0;
    req_ill = '0;
    for (int k = 0; k < N_LEG; k++) begin
      req_hi[k]  =  bus.i_signal[2*k] & ~bus.i_signal[2*k+1];
      req_lo[k]  = ~bus.i_signal[2*k] &  bus.i_signal[2*k+1];
      req_ill[k] =  bus.i_signal[2*k] &  bus.i_signal[2*k+1];
    end
  end

`ifdef DT_GLOBAL_TRIP_EN
  assign trip   = {N_LEG{|req_ill}};
  assign clr_ok = {N_LEG{bus.i_fault_clr & ~(|req_ill)}};
`else
  assign trip   = req_ill;
  assign clr_ok = {N_LEG{bus.i_fault_clr}} & ~req_ill;
`endif

  // A zero dead time still costs one cycle, so the load value saturates at 0.
  assign dt_load = (bus.i_deadtime == '0) ? '0 : bus.i_deadtime - DT_W'(1);

  always_comb begin
    target_d = target_q;
    fault_d  = fault_q;
    gate_d   = '0;
    dead_d   = '0;
    for (int k = 0; k < N_LEG; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];

      if (trip[k]) begin
        fault_d[k] = 1'b1;
      end else if (fault_q[k] && clr_ok[k]) begin
        fault_d[k] = 1'b0;
      end

      // A faulted leg stays OFF for the clearing edge too and resumes on the next one.
      if (!bus.i_enable || trip[k] || fault_q[k]) begin
        state_d[k] = ST_OFF;
        cnt_d[k]   = '0;
      end else begin
        case (state_q[k])
          ST_OFF, ST_HI_ON, ST_LO_ON: begin
            if (req_hi[k] && state_q[k] != ST_HI_ON) begin
              state_d[k]  = ST_DEAD;
              cnt_d[k]    = dt_load;
              target_d[k] = 1'b1;
            end else if (req_lo[k] && state_q[k] != ST_LO_ON) begin
              state_d[k]  = ST_DEAD;
              cnt_d[k]    = dt_load;
              target_d[k] = 1'b0;
            end else if (!req_hi[k] && !req_lo[k]) begin
              state_d[k] = ST_OFF;
            end
          end
          ST_DEAD: begin
            if (req_hi[k]) begin
              target_d[k] = 1'b1;
            end else if (req_lo[k]) begin
              target_d[k] = 1'b0;
            end
            if (cnt_q[k] != '0) begin
              cnt_d[k] = cnt_q[k] - DT_W'(1);
            end else if (req_hi[k]) begin
              state_d[k] = ST_HI_ON;
            end else if (req_lo[k]) begin
              state_d[k] = ST_LO_ON;
            end else begin
              state_d[k] = ST_OFF;
            end
          end
          default: state_d[k] = ST_OFF;
        endcase
      end

      gate_d[2*k]   = (state_d[k] == ST_HI_ON);
      gate_d[2*k+1] = (state_d[k] == ST_LO_ON);
      dead_d[k]     = (state_d[k] == ST_DEAD);
    end
  end

  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_LEG; k++) begin
        state_q[k] <= ST_OFF;
        cnt_q[k]   <= '0;
      end
      target_q <= '0;
      fault_q  <= '0;
      gate_q   <= '0;
      dead_q   <= '0;
    end else begin
      for (int k = 0; k < N_LEG; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      target_q <= target_d;
      fault_q  <= fault_d;
      gate_q   <= gate_d;
      dead_q   <= dead_d;
    end
  end

  assign bus.o_signal = gate_q;
  assign bus.o_dead   = dead_q;
  assign bus.o_fault  = fault_q;

endmodule

// File: tb/tb_dead_time_nleg.sv
// Scoreboard bench for dead_time_nleg: directed sequences queue cycle-tagged expectations,
// a negedge monitor compares them and checks the shoot-through invariant every cycle.
module tb_dead_time_nleg;
  localparam int N_LEG = 2;
  localparam int DT_W  = 8;
`ifdef DT_GLOBAL_TRIP_EN
  localparam bit GLOBAL = 1'b1;
`else
  localparam bit GLOBAL = 1'b0;
`endif

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic overlap;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dead_time_nleg_if #(.N_LEG(N_LEG), .DT_W(DT_W)) bus ();

  dead_time_nleg #(.N_LEG(N_LEG), .DT_W(DT_W)) dut (
    .i_clock (clk),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b want %b", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] sig, input logic [7:0] dt, input logic clr);
    bus.i_enable    = en;
    bus.i_signal    = sig;
    bus.i_deadtime  = dt;
    bus.i_fault_clr = clr;
  endtask

  // delta 0 is the next rising edge; expected packing is {o_signal, o_dead, o_fault}
  task automatic expectAt(input int delta, input string name,
                          input logic [3:0] s, input logic [1:0] d, input logic [1:0] f);
    exp_t e;
    e.cyc  = cyc + 1 + delta;
    e.name = name;
    e.exp  = {s, d, f};
    q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      overlap = 1'b0;
      for (int k = 0; k < N_LEG; k++) overlap |= bus.o_signal[2*k] & bus.o_signal[2*k+1];
      checkOutput("shoot_through", {7'b0, overlap}, 8'h00);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s missed: due cycle %0d, now %0d", e.name, e.cyc, cyc);
      end else begin
        checkOutput(e.name, {bus.o_signal, bus.o_dead, bus.o_fault}, e.exp);
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b0;
    applyStimulus(1'b1, 4'b0000, 8'd5, 1'b0);
    run(2);
    #1 checkOutput("reset_state", {bus.o_signal, bus.o_dead, bus.o_fault}, 8'h00);
    @(negedge clk) reset = 1'b1;

    // leg0 OFF -> HI with D=5, then HI -> LO
    applyStimulus(1'b1, 4'b0001, 8'd5, 1'b0);
    expectAt(0, "hi_dead_start", 4'b0000, 2'b01, 2'b00);
    expectAt(4, "hi_dead_end",   4'b0000, 2'b01, 2'b00);
    expectAt(5, "hi_rise",       4'b0001, 2'b00, 2'b00);
    run(6);
    applyStimulus(1'b1, 4'b0010, 8'd5, 1'b0);
    expectAt(0, "lo_hi_drop",    4'b0000, 2'b01, 2'b00);
    expectAt(4, "lo_dead_end",   4'b0000, 2'b01, 2'b00);
    expectAt(5, "lo_rise",       4'b0010, 2'b00, 2'b00);
    run(6);

    // D=0 behaves as 1; D=255 at the top of the range
    applyStimulus(1'b1, 4'b0001, 8'd0, 1'b0);
    expectAt(0, "d0_dead",       4'b0000, 2'b01, 2'b00);
    expectAt(1, "d0_rise",       4'b0001, 2'b00, 2'b00);
    run(2);
    applyStimulus(1'b1, 4'b0010, 8'd255, 1'b0);
    expectAt(0,   "d255_dead",   4'b0000, 2'b01, 2'b00);
    expectAt(254, "d255_late",   4'b0000, 2'b01, 2'b00);
    expectAt(255, "d255_rise",   4'b0010, 2'b00, 2'b00);
    run(256);

    // dead time is latched at the sampling edge
    applyStimulus(1'b1, 4'b0001, 8'd5, 1'b0);
    expectAt(0, "dchg_dead",     4'b0000, 2'b01, 2'b00);
    expectAt(5, "dchg_rise",     4'b0001, 2'b00, 2'b00);
    run(2);
    applyStimulus(1'b1, 4'b0001, 8'd20, 1'b0);
    run(4);
    applyStimulus(1'b1, 4'b0000, 8'd5, 1'b0);
    expectAt(0, "turn_off",      4'b0000, 2'b00, 2'b00);
    run(1);

    // leg1 illegal request, hold, and clear
    applyStimulus(1'b1, 4'b0001, 8'd3, 1'b0);
    expectAt(2, "d3_dead",       4'b0000, 2'b01, 2'b00);
    expectAt(3, "d3_rise",       4'b0001, 2'b00, 2'b00);
    run(4);
    applyStimulus(1'b1, 4'b1101, 8'd3, 1'b0);
    expectAt(0, "ill_trip", GLOBAL ? 4'b0000 : 4'b0001, 2'b00, GLOBAL ? 2'b11 : 2'b10);
    run(1);
    applyStimulus(1'b1, 4'b0101, 8'd3, 1'b0);
    expectAt(0, "ill_hold0", GLOBAL ? 4'b0000 : 4'b0001, 2'b00, GLOBAL ? 2'b11 : 2'b10);
    expectAt(2, "ill_hold2", GLOBAL ? 4'b0000 : 4'b0001, 2'b00, GLOBAL ? 2'b11 : 2'b10);
    run(3);
    applyStimulus(1'b1, 4'b0101, 8'd3, 1'b1);
    expectAt(0, "clr_edge",  GLOBAL ? 4'b0000 : 4'b0001, 2'b00, 2'b00);
    expectAt(1, "clr_dead",  GLOBAL ? 4'b0000 : 4'b0001, GLOBAL ? 2'b11 : 2'b10, 2'b00);
    expectAt(3, "clr_dead3", GLOBAL ? 4'b0000 : 4'b0001, GLOBAL ? 2'b11 : 2'b10, 2'b00);
    expectAt(4, "clr_rise",  4'b0101, 2'b00, 2'b00);
    run(1);
    applyStimulus(1'b1, 4'b0101, 8'd3, 1'b0);
    run(4);

    // illegal and clear on the same edge: the fault wins
    applyStimulus(1'b1, 4'b1101, 8'd3, 1'b1);
    expectAt(0, "ill_clr_same", GLOBAL ? 4'b0000 : 4'b0001, 2'b00, GLOBAL ? 2'b11 : 2'b10);
    run(1);
    applyStimulus(1'b1, 4'b0001, 8'd3, 1'b1);
    expectAt(0, "ill_clr_next", GLOBAL ? 4'b0000 : 4'b0001, 2'b00, 2'b00);
    run(1);

    // enable drop during DEAD, then a full delay after re-enable
    applyStimulus(1'b1, 4'b0010, 8'd5, 1'b0);
    expectAt(0, "en_dead",       4'b0000, 2'b01, 2'b00);
    run(2);
    applyStimulus(1'b0, 4'b0010, 8'd5, 1'b0);
    expectAt(0, "en_off",        4'b0000, 2'b00, 2'b00);
    run(1);
    applyStimulus(1'b1, 4'b0001, 8'd5, 1'b0);
    expectAt(0, "reen_dead",     4'b0000, 2'b01, 2'b00);
    expectAt(4, "reen_dead4",    4'b0000, 2'b01, 2'b00);
    expectAt(5, "reen_rise",     4'b0001, 2'b00, 2'b00);
    run(6);

    // target flips back during DEAD without restarting the count
    applyStimulus(1'b1, 4'b0010, 8'd4, 1'b0);
    expectAt(0, "tgt_dead",      4'b0000, 2'b01, 2'b00);
    expectAt(3, "tgt_dead3",     4'b0000, 2'b01, 2'b00);
    expectAt(4, "tgt_rise_hi",   4'b0001, 2'b00, 2'b00);
    run(2);
    applyStimulus(1'b1, 4'b0001, 8'd4, 1'b0);
    run(3);

    // request withdrawn during DEAD resolves to OFF
    applyStimulus(1'b1, 4'b0010, 8'd2, 1'b0);
    expectAt(0, "wd_dead",       4'b0000, 2'b01, 2'b00);
    expectAt(1, "wd_dead1",      4'b0000, 2'b01, 2'b00);
    expectAt(2, "wd_off",        4'b0000, 2'b00, 2'b00);
    run(1);
    applyStimulus(1'b1, 4'b0000, 8'd2, 1'b0);
    run(2);

    // random soak; the monitor checks the invariant each cycle
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(15, 0) != 0, 4'($urandom_range(15, 0)),
                    8'($urandom_range(3, 0)), $urandom_range(7, 0) == 0);
      run(1);
    end

    // bring leg0 to HI_ON, then assert reset asynchronously
    applyStimulus(1'b1, 4'b0001, 8'd1, 1'b1);
    expectAt(3, "pre_reset_hi",  4'b0001, 2'b00, 2'b00);
    run(4);
    applyStimulus(1'b1, 4'b0001, 8'd1, 1'b0);
    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      run(1);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left", q.size());
    end
    #2 reset = 1'b0;
    #1 checkOutput("async_reset", {bus.o_signal, bus.o_dead, bus.o_fault}, 8'h00);
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
